// File: rtl/overlap_add_buffer.sv
// rtl/overlap_add_buffer.sv - circular overlap-add accumulator with saturating hop output
module overlap_add_buffer #(
    parameter int DWIDTH    = 24,
    parameter int FRAME_LEN = 1024,
    parameter int HOP       = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] frame_in_tdata,
    input  logic              frame_in_tvalid,
    output logic              frame_in_tready,
    input  logic              frame_in_tlast,
    output logic [DWIDTH-1:0] sample_out_tdata,
    output logic              sample_out_tvalid,
    input  logic              sample_out_tready,
    output logic              sample_out_tlast,
    output logic              frame_err
);

    localparam int AW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int AWIDTH = DWIDTH + 2;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // cnt is the clear index in CLEAR, the beat index k in ACCUM and the
    // hop index j in DRAIN; the three uses never overlap in time.
    logic [AW-1:0] base, base_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          err_q, err_nxt;

    logic signed [AWIDTH-1:0] mem [FRAME_LEN];

    logic [AW-1:0]            rd_addr;
    logic signed [AWIDTH-1:0] rd_val;
    logic signed [AWIDTH-1:0] in_ext;
    logic                     fits;
    logic [DWIDTH-1:0]        sat_val;

    logic                     mem_we;
    logic [AW-1:0]            mem_waddr;
    logic signed [AWIDTH-1:0] mem_wdata;

    assign rd_addr = base + cnt;
    assign rd_val  = mem[rd_addr];
    assign in_ext  = {{2{frame_in_tdata[DWIDTH-1]}}, frame_in_tdata};

    // The value fits the output width when the top three bits agree.
    assign fits    = (rd_val[AWIDTH-1:DWIDTH-1] == {3{rd_val[AWIDTH-1]}});
    assign sat_val = fits ? rd_val[DWIDTH-1:0]
                          : {rd_val[AWIDTH-1], {(DWIDTH-1){~rd_val[AWIDTH-1]}}};

    // Outputs decode straight from state so they are inactive right after reset.
    assign frame_in_tready   = (state == S_ACCUM);
    assign sample_out_tvalid = (state == S_DRAIN);
    assign sample_out_tdata  = (state == S_DRAIN) ? sat_val : '0;
    assign sample_out_tlast  = (state == S_DRAIN) && (cnt == AW'(HOP - 1));
    assign frame_err         = err_q;

    // Next-state, pointer updates and the single accumulator write port.
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = rd_addr;
        mem_wdata = '0;
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == AW'(FRAME_LEN - 1)) begin
                    state_nxt = S_ACCUM;
                    base_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            S_ACCUM: begin
                if (frame_in_tvalid) begin
                    // Read-modify-write in one cycle; successive beats hit
                    // distinct entries so there is no hazard to forward.
                    mem_we    = 1'b1;
                    mem_wdata = rd_val + in_ext;
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == AW'(FRAME_LEN - 1)) begin
                        err_nxt   = ~frame_in_tlast;
                        state_nxt = S_DRAIN;
                        cnt_nxt   = '0;
                    end else if (frame_in_tlast) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DRAIN;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (sample_out_tready) begin
                    mem_we    = 1'b1;
                    mem_wdata = '0;
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == AW'(HOP - 1)) begin
                        base_nxt  = base + AW'(HOP);
                        cnt_nxt   = '0;
                        state_nxt = S_ACCUM;
                    end
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, pointer and error-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_CLEAR;
            base  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            base  <= base_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    // Accumulator storage; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_overlap_add_buffer.sv
// tb/tb_overlap_add_buffer.sv - directed and randomised checks of overlap_add_buffer
module tb_overlap_add_buffer;

    logic        clk;
    logic        reset;
    logic [23:0] frame_in_tdata;
    logic        frame_in_tvalid;
    logic        frame_in_tready;
    logic        frame_in_tlast;
    logic [23:0] sample_out_tdata;
    logic        sample_out_tvalid;
    logic        sample_out_tready;
    logic        sample_out_tlast;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    logic [23:0] fdata [8];
    longint      macc  [8];
    int          mbase;
    logic        last_err;

    overlap_add_buffer #(.DWIDTH(24), .FRAME_LEN(8), .HOP(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_in_tdata    (frame_in_tdata),
        .frame_in_tvalid   (frame_in_tvalid),
        .frame_in_tready   (frame_in_tready),
        .frame_in_tlast    (frame_in_tlast),
        .sample_out_tdata  (sample_out_tdata),
        .sample_out_tvalid (sample_out_tvalid),
        .sample_out_tready (sample_out_tready),
        .sample_out_tlast  (sample_out_tlast),
        .frame_err         (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [23:0] sat24(input longint v);
        if (v > 64'sd8388607)
            return 24'h7FFFFF;
        else if (v < -64'sd8388608)
            return 24'h800000;
        else
            return 24'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) macc[i] = 0;
        mbase = 0;
    endtask

    task automatic fill(input logic [23:0] v);
        for (int i = 0; i < 8; i++) fdata[i] = v;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        frame_in_tvalid   = 1'b0;
        frame_in_tlast    = 1'b0;
        sample_out_tready = 1'b0;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        model_clear();
        checks++;
        if (frame_in_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", frame_in_tready);
        end
    endtask

    task automatic send_frame(input int n, input int last_at, input bit gaps);
        int t;
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                frame_in_tvalid = 1'b0;
                @(negedge clk);
            end
            t = 0;
            while (!frame_in_tready && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (!frame_in_tready) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: beat %0d never accepted", k);
                return;
            end
            frame_in_tvalid = 1'b1;
            frame_in_tdata  = fdata[k];
            frame_in_tlast  = (k == last_at);
            @(negedge clk);
            macc[(mbase + k) % 8] += longint'($signed(fdata[k]));
            last_err = frame_err;
            if (k != n - 1) begin
                checks++;
                if (frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_err: beat %0d got %b want 0", k, frame_err);
                end
            end
        end
        frame_in_tvalid = 1'b0;
        frame_in_tlast  = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready low for 5 cycles first; 2: random ready
    task automatic drain_hop(input logic [23:0] exp0, input logic [23:0] exp1, input int mode);
        logic [23:0] e [2];
        int got;
        int cyc;
        logic rdy;
        e[0] = exp0;
        e[1] = exp1;
        got  = 0;
        cyc  = 0;
        while (got < 2 && cyc < 200) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc >= 5);
            else                rdy = 1'($urandom_range(0, 1));
            checks++;
            if (sample_out_tvalid && frame_in_tready) begin
                errors++;
                $display("FAIL exclusive: ready and valid both high at cycle %0d", cyc);
            end
            if (mode == 1 && cyc < 5) begin
                checks++;
                if (sample_out_tvalid !== 1'b1 || sample_out_tdata !== e[0] || sample_out_tlast !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b want 1 %h 0",
                             sample_out_tvalid, sample_out_tdata, sample_out_tlast, e[0]);
                end
            end
            sample_out_tready = rdy;
            if (sample_out_tvalid && rdy) begin
                checks++;
                if (sample_out_tdata !== e[got] || sample_out_tlast !== (got == 1)) begin
                    errors++;
                    $display("FAIL sample_%0d: got %h last=%b want %h last=%b",
                             got, sample_out_tdata, sample_out_tlast, e[got], (got == 1));
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        sample_out_tready = 1'b0;
        if (got < 2) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d samples want 2", got);
        end
        for (int j = 0; j < 2; j++) macc[(mbase + j) % 8] = 0;
        mbase = (mbase + 2) % 8;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (frame_in_tready !== 1'b0 || sample_out_tvalid !== 1'b0 || sample_out_tlast !== 1'b0 ||
            sample_out_tdata !== 24'h0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b last=%b data=%h err=%b want all 0",
                     frame_in_tready, sample_out_tvalid, sample_out_tlast, sample_out_tdata, frame_err);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (frame_in_tready !== 1'b0 || sample_out_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL clear_cycle_%0d: rdy=%b vld=%b want 0 0", i, frame_in_tready, sample_out_tvalid);
            end
            @(negedge clk);
        end
        checks++;
        if (frame_in_tready !== 1'b1) begin
            errors++;
            $display("FAIL clear_exit: ready got %b want 1", frame_in_tready);
        end
        model_clear();
    endtask

    task automatic test_basic();
        fill(24'h000100);
        send_frame(8, 7, 0);
        checks++;
        if (last_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: got %b want 0", last_err);
        end
        drain_hop(24'h000100, 24'h000100, 0);
        send_frame(8, 7, 0);
        drain_hop(24'h000200, 24'h000200, 0);
    endtask

    task automatic test_saturation();
        apply_reset();
        fill(24'h400000);
        for (int h = 0; h < 4; h++) begin
            send_frame(8, 7, 0);
            if (h == 0) drain_hop(24'h400000, 24'h400000, 0);
            else        drain_hop(24'h7FFFFF, 24'h7FFFFF, 0);
        end
        apply_reset();
        fill(24'hC00000);
        for (int h = 0; h < 4; h++) begin
            send_frame(8, 7, 0);
            if (h == 0) drain_hop(24'hC00000, 24'hC00000, 0);
            else        drain_hop(24'h800000, 24'h800000, 0);
        end
    endtask

    task automatic test_frame_err();
        apply_reset();
        fill(24'h000100);
        send_frame(4, 3, 0);
        checks++;
        if (last_err !== 1'b1 || sample_out_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL early_last: err=%b vld=%b want 1 1", last_err, sample_out_tvalid);
        end
        sample_out_tready = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || sample_out_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse_width: err=%b vld=%b want 0 1", frame_err, sample_out_tvalid);
        end
        drain_hop(24'h000100, 24'h000100, 0);
        send_frame(8, -1, 0);
        checks++;
        if (last_err !== 1'b1 || sample_out_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL missing_last: err=%b vld=%b want 1 1", last_err, sample_out_tvalid);
        end
        drain_hop(24'h000200, 24'h000200, 0);
    endtask

    task automatic test_stall();
        apply_reset();
        for (int k = 0; k < 8; k++) fdata[k] = 24'h000001 + 24'(k * 16);
        send_frame(8, 7, 0);
        drain_hop(24'h000001, 24'h000011, 1);
    endtask

    task automatic test_random();
        logic [23:0] e0;
        logic [23:0] e1;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 8; k++) fdata[k] = 24'($urandom);
            send_frame(8, 7, 1);
            checks++;
            if (last_err !== 1'b0) begin
                errors++;
                $display("FAIL random_err_%0d: got %b want 0", f, last_err);
            end
            e0 = sat24(macc[mbase]);
            e1 = sat24(macc[(mbase + 1) % 8]);
            drain_hop(e0, e1, 2);
        end
    endtask

    task automatic test_reset_mid();
        fill(24'h123456);
        send_frame(4, -1, 0);
        frame_in_tvalid = 1'b1;
        frame_in_tdata  = 24'h123456;
        apply_reset();
        fill(24'h000010);
        send_frame(8, 7, 0);
        drain_hop(24'h000010, 24'h000010, 0);
    endtask

    initial begin
        reset             = 1'b0;
        frame_in_tdata    = '0;
        frame_in_tvalid   = 1'b0;
        frame_in_tlast    = 1'b0;
        sample_out_tready = 1'b0;
        last_err          = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_saturation();
        test_frame_err();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/overlap_add_buffer.md
OVERLAP_ADD_BUFFER -- requirements
Module: overlap_add_buffer

Interface
REQ-001 SHALL have parameter DWIDTH, default 24, meaning the signed sample width on both streams.
REQ-002 SHALL have parameter FRAME_LEN, default 1024, meaning the samples per input frame (power of 2).
REQ-003 SHALL have parameter HOP, default 256, meaning the output samples emitted per frame (power of 2, HOP <= FRAME_LEN).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port frame_in  Axis_If.Slave (DWIDTH=24)  data/valid/ready/last  carrying time-domain synthesis frames; last marks the final beat of a frame.
REQ-007 SHALL have port sample_out  Axis_If.Master (DWIDTH=24)  data/valid/ready/last  carrying reconstructed audio samples; last marks the final sample of each hop.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a frame-length violation.

Function
REQ-009 SHALL hold a circular accumulator RAM of FRAME_LEN entries, each DWIDTH+2 bits signed, plus a base pointer (log2 FRAME_LEN bits, wraps modulo FRAME_LEN).
REQ-010 SHALL implement the state machine CLEAR -> ACCUM -> DRAIN -> ACCUM, with no other transitions except reset.
REQ-011 CLEAR: SHALL write 0 to every RAM entry, one per cycle (FRAME_LEN cycles), with frame_in.ready=0 and sample_out.valid=0, then enter ACCUM with base=0.
REQ-012 ACCUM: SHALL drive frame_in.ready=1; beat k (k=0..FRAME_LEN-1) SHALL do mem[(base+k) mod FRAME_LEN] += sign-extended data via a read-modify-write pipeline that sustains one beat per cycle.
REQ-013 ACCUM: an accepted beat SHALL be one with valid&&ready; valid low SHALL stall k without side effects.
REQ-014 ACCUM: after beat FRAME_LEN-1 is accepted, SHALL drop ready on the next cycle, let the pending write retire, and enter DRAIN.
REQ-015 Early frame_in.last (k<FRAME_LEN-1) SHALL pulse frame_err, end the frame (remaining positions are unmodified, i.e. add 0), and enter DRAIN.
REQ-016 A missing last on beat FRAME_LEN-1 SHALL pulse frame_err; the frame SHALL still complete normally.
REQ-017 DRAIN: SHALL emit mem[(base+j) mod FRAME_LEN] for j=0..HOP-1 in order, clearing each entry to 0 once its handshake completes.
REQ-018 DRAIN: sample_out.data SHALL be the accumulator value saturated to the signed DWIDTH range (max 0x7FFFFF, min 0x800000 at default width).
REQ-019 DRAIN: sample_out.last SHALL be 1 only on j=HOP-1.
REQ-020 DRAIN: data/valid/last SHALL be held stable while valid=1 and ready=0.
REQ-021 DRAIN: the first sample_out.valid SHALL assert no later than 2 cycles after entering DRAIN; output throughput SHALL be one sample per cycle under continuous ready.
REQ-022 DRAIN: after the j=HOP-1 handshake, SHALL set base=(base+HOP) mod FRAME_LEN and return to ACCUM.
REQ-023 Accumulator addition SHALL use full DWIDTH+2-bit two's-complement width; no internal saturation.
REQ-024 frame_in.ready and sample_out.valid SHALL never both be 1 in the same cycle.

Reset
REQ-025 While reset=0 on a rising edge, the block SHALL set state=CLEAR, base=0, clear the clear counter, and drive frame_in.ready=0, sample_out.valid=0, sample_out.last=0, sample_out.data=0, frame_err=0.
REQ-026 Reset asserted mid-ACCUM or mid-DRAIN SHALL abandon the frame or hop and re-run CLEAR, so no stale accumulator content survives.
REQ-027 After reset release, frame_in.ready SHALL stay 0 for exactly FRAME_LEN cycles (CLEAR).

Verification (FRAME_LEN=8, HOP=2, DWIDTH=24)
REQ-028 Reset, release -> ready=0 for 8 cycles, then ready=1; sample_out.valid=0 throughout.
REQ-029 Feed one frame of all 0x000100 with last on beat 7 -> outputs 0x000100, 0x000100 (last on 2nd); feed a 2nd identical frame -> outputs 0x000200, 0x000200.
REQ-030 Feed four consecutive 0x400000 frames -> by the 4th hop the sum is 0x1000000, output saturates to 0x7FFFFF; the negative mirror (0xC00000) gives 0x800000.
REQ-031 Assert last on beat 3 -> frame_err pulses for 1 cycle, then DRAIN begins; assert no last on beat 7 -> frame_err pulses, frame completes.
REQ-032 Hold sample_out.ready=0 for 5 cycles during DRAIN -> data/valid/last stay stable, no sample lost or duplicated; random ready over 16 frames -> base wraps 6->0 correctly and the output matches a golden overlap-add model.
REQ-033 Assert reset on beat 4 of ACCUM -> full CLEAR, after which a fresh frame of 0x000010 yields outputs of exactly 0x000010.
